// File: rtl/lstm_weight_seq.sv
// lstm_weight_seq: read-address sequencer for the LSTM weight/bias ROM.
// A pass walks every hidden row; each row emits one bias beat, then
// 4*COL recurrent (Whh) weight addresses, then 4*COW input (Wih) weight
// addresses, over a valid/ready stream with all outputs registered.
// Optional build macro: LSTM_SEQ_STALL_CNT_EN enables the stall counter
// on stall_cnt; without it stall_cnt is tied to zero.
module lstm_weight_seq #(
   parameter int COL       = 512,
   parameter int COW       = 96,
   parameter int RAMADDR_W = $clog2(COL*COL*4 + COL*COW*4),
   parameter int ADDR_B    = $clog2(COL*4)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [1:0]                out_kind,
   output logic [RAMADDR_W-1:0]      addr_w,
   output logic [ADDR_B-1:0]         addr_b,
   output logic [1:0]                out_gate,
   output logic [$clog2(COL)-1:0]    out_row,
   output logic                      row_last,
   output logic [31:0]               stall_cnt
);

   localparam int ROW_W = $clog2(COL);
   localparam int KMAX  = (COL > COW) ? COL : COW;
   localparam int KW    = (KMAX > 1) ? $clog2(KMAX) : 1;

   // Wih block sits directly above the Whh block in the unified space
   localparam logic [RAMADDR_W-1:0] WIH_BASE   = RAMADDR_W'(4*COL*COL);
   localparam logic [KW-1:0]        K_WHH_LAST = KW'(COL-1);
   localparam logic [KW-1:0]        K_WIH_LAST = KW'(COW-1);
   localparam logic [ROW_W-1:0]     ROW_LAST   = ROW_W'(COL-1);

   localparam logic [1:0] KIND_BIAS = 2'd0;
   localparam logic [1:0] KIND_WHH  = 2'd1;
   localparam logic [1:0] KIND_WIH  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BIAS = 3'd1,
      S_WHH  = 3'd2,
      S_WIH  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t                 state_reg, state_next;
   logic [ROW_W-1:0]       row_reg,   row_next;
   logic [KW-1:0]          k_reg,     k_next;
   logic [1:0]             g_reg,     g_next;
   logic [RAMADDR_W-1:0]   pw_reg,    pw_next;
   logic [RAMADDR_W-1:0]   pi_reg,    pi_next;

   // registered copies of every output, computed from the next-state values
   logic                   busy_reg,     busy_next;
   logic                   done_reg,     done_next;
   logic                   valid_reg,    valid_next;
   logic [1:0]             kind_reg,     kind_next;
   logic [RAMADDR_W-1:0]   addr_w_reg,   addr_w_next;
   logic [ADDR_B-1:0]      addr_b_reg,   addr_b_next;
   logic [1:0]             gate_reg,     gate_next;
   logic [ROW_W-1:0]       out_row_reg,  out_row_next;
   logic                   row_last_reg, row_last_next;

   logic                   accept;

   assign accept = valid_reg && out_ready;

   // Next-state, counter stepping and next output values. Without an accept
   // every next value equals the current one, so outputs hold during stalls.
   always_comb begin
      state_next    = state_reg;
      row_next      = row_reg;
      k_next        = k_reg;
      g_next        = g_reg;
      pw_next       = pw_reg;
      pi_next       = pi_reg;
      busy_next     = 1'b0;
      done_next     = 1'b0;
      valid_next    = 1'b0;
      kind_next     = KIND_BIAS;
      addr_w_next   = '0;
      addr_b_next   = '0;
      gate_next     = 2'd0;
      out_row_next  = '0;
      row_last_next = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_BIAS;
               row_next   = '0;
               k_next     = '0;
               g_next     = 2'd0;
               pw_next    = '0;
               pi_next    = WIH_BASE;
            end
         end
         S_BIAS: begin
            if (accept) begin
               state_next = S_WHH;
               k_next     = '0;
               g_next     = 2'd0;
            end
         end
         S_WHH: begin
            if (accept) begin
               // Whh addresses are contiguous over the whole pass
               pw_next = pw_reg + 1'b1;
               g_next  = g_reg + 2'd1;
               if (g_reg == 2'd3) begin
                  if (k_reg == K_WHH_LAST) begin
                     k_next     = '0;
                     state_next = S_WIH;
                  end else begin
                     k_next = k_reg + 1'b1;
                  end
               end
            end
         end
         S_WIH: begin
            if (accept) begin
               pi_next = pi_reg + 1'b1;
               g_next  = g_reg + 2'd1;
               if (g_reg == 2'd3) begin
                  if (k_reg == K_WIH_LAST) begin
                     k_next = '0;
                     if (row_reg == ROW_LAST) begin
                        state_next = S_FIN;
                     end else begin
                        row_next   = row_reg + 1'b1;
                        state_next = S_BIAS;
                     end
                  end else begin
                     k_next = k_reg + 1'b1;
                  end
               end
            end
         end
         S_FIN: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Output image of the state being entered
      case (state_next)
         S_BIAS: begin
            busy_next    = 1'b1;
            valid_next   = 1'b1;
            kind_next    = KIND_BIAS;
            addr_b_next  = ADDR_B'(row_next);
            out_row_next = row_next;
         end
         S_WHH: begin
            busy_next    = 1'b1;
            valid_next   = 1'b1;
            kind_next    = KIND_WHH;
            addr_w_next  = pw_next;
            addr_b_next  = ADDR_B'(row_next);
            gate_next    = g_next;
            out_row_next = row_next;
         end
         S_WIH: begin
            busy_next     = 1'b1;
            valid_next    = 1'b1;
            kind_next     = KIND_WIH;
            addr_w_next   = pi_next;
            addr_b_next   = ADDR_B'(row_next);
            gate_next     = g_next;
            out_row_next  = row_next;
            row_last_next = (k_next == K_WIH_LAST) && (g_next == 2'd3);
         end
         S_FIN: begin
            done_next = 1'b1;
         end
         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

   // State, counters and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         row_reg      <= '0;
         k_reg        <= '0;
         g_reg        <= 2'd0;
         pw_reg       <= '0;
         pi_reg       <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         kind_reg     <= KIND_BIAS;
         addr_w_reg   <= '0;
         addr_b_reg   <= '0;
         gate_reg     <= 2'd0;
         out_row_reg  <= '0;
         row_last_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         row_reg      <= row_next;
         k_reg        <= k_next;
         g_reg        <= g_next;
         pw_reg       <= pw_next;
         pi_reg       <= pi_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         valid_reg    <= valid_next;
         kind_reg     <= kind_next;
         addr_w_reg   <= addr_w_next;
         addr_b_reg   <= addr_b_next;
         gate_reg     <= gate_next;
         out_row_reg  <= out_row_next;
         row_last_reg <= row_last_next;
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign out_valid = valid_reg;
   assign out_kind  = kind_reg;
   assign addr_w    = addr_w_reg;
   assign addr_b    = addr_b_reg;
   assign out_gate  = gate_reg;
   assign out_row   = out_row_reg;
   assign row_last  = row_last_reg;

`ifdef LSTM_SEQ_STALL_CNT_EN
   logic [31:0] stall_cnt_reg;

   // Saturating count of back-pressure cycles, restarted by each accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if ((state_reg == S_IDLE) && start) begin
         stall_cnt_reg <= '0;
      end else if (valid_reg && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/lstm_weight_seq.md
Name: lstm_weight_seq

Overview:
- Read-address sequencer for the LSTM weight/bias ROM.
- On `start`, walks all `COL` hidden rows. Per row it emits:
  - one bias beat,
  - then 4*`COL` recurrent (Whh) weight addresses,
  - then 4*`COW` input (Wih) weight addresses.
- Uses the ROM's unified address space: Whh at 0..4*`COL`*`COL`-1, Wih above it; gate index in addr[1:0].
- Sits between the LSTM top-level control and the ROM, feeding the MAC array through a valid/ready stream.

Parameters:
- `COL`, 512, hidden size (rows; Whh columns).
- `COW`, 96, input size (Wih columns).
- `RAMADDR_W`, $clog2(`COL`*`COL`*4+`COL`*`COW`*4), unified weight address width.
- `ADDR_B`, $clog2(`COL`*4), bias address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to run a full pass; ignored while busy.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `out_valid`  out  1  beat present.
- `out_ready`  in  1  consumer accepts beat when valid&&ready.
- `out_kind`  out  2  0=bias, 1=Whh, 2=Wih, 3 unused.
- `addr_w`  out  `RAMADDR_W`  unified weight address (valid for kind 1/2).
- `addr_b`  out  `ADDR_B`  bias row address, equal to current row (valid for kind 0).
- `out_gate`  out  2  gate index, equal to addr_w[1:0] for weights, 0 for bias.
- `out_row`  out  $clog2(`COL`)  current row.
- `row_last`  out  1  marks the final Wih beat of a row.
- `stall_cnt`  out  32  see Optional Feature.

Behaviour:
- Reset: `busy`=0, `done`=0, `out_valid`=0, `out_kind`=0, `addr_w`=0, `addr_b`=0, `out_gate`=0, `out_row`=0, `row_last`=0. FSM goes to IDLE.
- `rst` mid-pass aborts immediately; no `done` pulse.
- FSM states: IDLE, BIAS, WHH, WIH, FIN.
  - IDLE: `start`=1 → BIAS next cycle. Row=0; Whh pointer pw=0; Wih pointer pi=4*`COL`*`COL`.
  - BIAS: `out_valid`=1, kind=0, `addr_b`=row. On accept → WHH with k=0, g=0.
  - WHH: `addr_w`=pw, kind=1. On accept: pw+=1 and g+=1 (wrap 3→0, then k+=1). After accepting k=`COL`-1, g=3 → WIH.
  - WIH: `addr_w`=pi, kind=2. On accept: pi+=1, same g/k stepping. `row_last`=1 on k=`COW`-1, g=3. On accepting that beat:
    - row<`COL`-1: row+=1 → BIAS.
    - otherwise → FIN.
  - FIN: `out_valid`=0, `done`=1 for one cycle, `busy`=0 → IDLE.
- Address sequences:
  - Whh addresses equal 4*(row*`COL`+k)+g. They are contiguous across the whole pass, so pw is a plain incrementer with no multiplier.
  - Wih addresses equal 4*`COL`*`COL`+4*(row*`COW`+k)+g, also contiguous.
- Outputs are registered. All outputs, including `out_valid`, hold stable while `out_valid`&&!`out_ready`. `out_valid` never drops without acceptance except on `rst`.
- Zero-bubble throughput: one beat per cycle while `out_ready`=1. This includes the BIAS→WHH, WHH→WIH and WIH→BIAS transitions.
- Pass length: `COL`*(1+4*`COL`+4*`COW`) accepted beats. `done` asserts the cycle after the last accept.
- `start` while busy is ignored. `start` in the same cycle as `done` is also ignored; `start` is accepted only in IDLE.
- Counter widths are sized to their ranges; no wrap occurs within a legal pass.

Optional Feature:
- Macro `LSTM_SEQ_STALL_CNT_EN`.
- Defined: `stall_cnt` counts cycles with `out_valid`&&!`out_ready`. It clears to 0 on accepted `start` and on `rst`, saturates at 2^32-1, and holds after `done`.
- Undefined: `stall_cnt` is constant 0 and no counter logic is built.

Test Plan (`COL`=4, `COW`=2 unless noted):
- Reset then idle, `out_ready`=1, no `start` → `out_valid`=0, `busy`=0, `done` never pulses, all outputs 0.
- `start` pulse, `out_ready`=1 throughout → 100 consecutive beats with no bubbles, then `done` pulses the next cycle.
  - Row0: bias `addr_b`=0; Whh `addr_w` 0..15; Wih 64..71.
  - Row3: bias `addr_b`=3; Whh 48..63; Wih 88..95.
- Random `out_ready` (50%) → identical accepted beat sequence to the previous test. Outputs hold stable during stalls. With `LSTM_SEQ_STALL_CNT_EN`, `stall_cnt` equals the number of stall cycles.
- `row_last` check → `row_last`=1 exactly on `addr_w`=71, 79, 87, 95, and 0 elsewhere.
- `start` re-pulsed mid-pass and again in the `done` cycle → ignored; beat count stays 100. `start` one cycle after `done` begins a new pass at bias row 0.
- `rst` asserted during WHH of row 2 → next cycle `out_valid`=0, `busy`=0, no `done`. A later `start` restarts at row 0, `addr_w`=0.
